// File: rtl/pipe_stage_reg.sv
// Elastic multi-stage pipeline register with valid/ready backpressure, bubble collapsing and flush.
// Optional retire/flush statistics counters enabled by defining PIPE_STAGE_STATS_EN.
module pipe_stage_reg #(
   parameter int DATA_W = 32,
   parameter int INST_W = 32,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 2,
   parameter int DEPTH  = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CTRL_W-1:0]          in_ctrl,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [RD_W-1:0]            in_rd,
   input  logic [INST_W-1:0]          in_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CTRL_W-1:0]          out_ctrl,
   output logic [DATA_W-1:0]          out_data,
   output logic [RD_W-1:0]            out_rd,
   output logic [INST_W-1:0]          out_inst,
   output logic [$clog2(DEPTH+1)-1:0] occupancy
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [31:0]                stat_retired,
   output logic [31:0]                stat_flushed
`endif
);

   localparam int OCC_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] data;
      logic [RD_W-1:0]   rd;
      logic [INST_W-1:0] inst;
   } payload_t;

   logic [DEPTH-1:0]     v_q, v_nxt, rdy, src_v;
   payload_t [DEPTH-1:0] pl_q, src_p;
   logic [OCC_W-1:0]     occ_q;
   logic                 accept, hs;

   function automatic logic [OCC_W-1:0] popcnt(input logic [DEPTH-1:0] x);
      logic [OCC_W-1:0] c;
      c = '0;
      for (int i = 0; i < DEPTH; i++) c = c + OCC_W'(x[i]);
      return c;
   endfunction

   // A stage can advance when any stage at or downstream of it is empty,
   // or the head retires; written flat to avoid a self-referencing chain.
   always_comb begin
      rdy = '0;
      for (int i = 0; i < DEPTH; i++)
         rdy[i] = out_ready || ((~v_q >> i) != '0);
   end

   always_comb begin
      in_ready = rdy[0] && !flush;
      accept   = in_valid && in_ready;
      src_v    = (v_q << 1) | DEPTH'(accept);
      src_p    = '0;
      src_p[0] = '{ctrl: in_ctrl, data: in_data, rd: in_rd, inst: in_inst};
      for (int i = 1; i < DEPTH; i++) src_p[i] = pl_q[i-1];
      v_nxt    = flush ? '0 : ((rdy & src_v) | (~rdy & v_q));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q   <= '0;
         pl_q  <= '0;
         occ_q <= '0;
      end else begin
         v_q   <= v_nxt;
         occ_q <= popcnt(v_nxt);
         // Bubbles leave the payload untouched; only real entries load.
         for (int i = 0; i < DEPTH; i++)
            if (rdy[i] && src_v[i]) pl_q[i] <= src_p[i];
      end
   end

   assign hs        = v_q[DEPTH-1] && out_ready;
   assign out_valid = v_q[DEPTH-1];
   assign out_ctrl  = v_q[DEPTH-1] ? pl_q[DEPTH-1].ctrl : '0;
   assign out_data  = pl_q[DEPTH-1].data;
   assign out_rd    = pl_q[DEPTH-1].rd;
   assign out_inst  = pl_q[DEPTH-1].inst;
   assign occupancy = occ_q;

`ifdef PIPE_STAGE_STATS_EN
   // A head entry retiring in the flush cycle is not counted as killed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_retired <= '0;
         stat_flushed <= '0;
      end else begin
         if (hs) stat_retired <= stat_retired + 32'd1;
         if (flush) stat_flushed <= stat_flushed + 32'(occ_q) - 32'(hs);
      end
   end
`endif

endmodule
